unidade_controle_rodadas: RTL and testbench

- Moore FSM that sequences the memory-game datapath over successive rounds. Round N requires plays 0..N.
- Drives the position counter (C), the play register (R) and the round-limit counter (L) in the datapath.
- Optionally enforces a per-play timeout with an internal cycle counter.
- Replaces the single-round controller in the next experiment's top level. The 4-bit state code goes to a hexa7seg display.

---
 rtl/unidade_controle_rodadas_pkg.sv | 33 +++
 rtl/unidade_controle_rodadas_contador_timeout.sv | 25 ++
 rtl/unidade_controle_rodadas.sv | 117 +++++++++++
 tb/tb_unidade_controle_rodadas.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_rodadas_pkg.sv
// State codes shared by the round controller, the top level and the benches,
// so that db_estado values match everywhere.
package exp5_pkg;

   localparam logic [3:0] INICIAL       = 4'h0;
   localparam logic [3:0] PREPARA       = 4'h1;
   localparam logic [3:0] INICIO_RODADA = 4'h2;
   localparam logic [3:0] ESPERA        = 4'h3;
   localparam logic [3:0] REGISTRA      = 4'h4;
   localparam logic [3:0] COMPARA       = 4'h5;
   localparam logic [3:0] PROX_JOGADA   = 4'h6;
   localparam logic [3:0] PROX_RODADA   = 4'h7;
   localparam logic [3:0] FIM_ACERTO    = 4'hA;
   localparam logic [3:0] FIM_ERRO      = 4'hE;
   localparam logic [3:0] FIM_TIMEOUT   = 4'hC;

   localparam int TIMEOUT_CYCLES_DEF = 5000;

   typedef enum logic [3:0] {
      S_INICIAL       = INICIAL,
      S_PREPARA       = PREPARA,
      S_INICIO_RODADA = INICIO_RODADA,
      S_ESPERA        = ESPERA,
      S_REGISTRA      = REGISTRA,
      S_COMPARA       = COMPARA,
      S_PROX_JOGADA   = PROX_JOGADA,
      S_PROX_RODADA   = PROX_RODADA,
      S_FIM_ACERTO    = FIM_ACERTO,
      S_FIM_ERRO      = FIM_ERRO,
      S_FIM_TIMEOUT   = FIM_TIMEOUT
   } estado_t;

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-play cycle counter; fim flags the last allowed cycle while counting.
module contador_timeout #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   output logic fim
);

   localparam int W = $clog2(TIMEOUT_CYCLES);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)       cnt_d = '0;
      else if (enable) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock) cnt_q <= cnt_d;

   assign fim = enable && (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore controller sequencing the memory game over successive rounds.
// Per-play timeout is built only when UNIDADE_CONTROLE_RODADAS_TIMEOUT_EN is defined.
module unidade_controle_rodadas
   import exp5_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fimC,
   input  logic       fimL,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       zeraL,
   output logic       contaL,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic       pronto,
   output logic [3:0] db_estado
);

   estado_t state_q, state_d;
   logic    expirou;

`ifdef UNIDADE_CONTROLE_RODADAS_TIMEOUT_EN
   // Cleared whenever the next state is not ESPERA, so every entry starts at 0.
   contador_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clock  (clock),
      .clear  (reset || (state_d != S_ESPERA)),
      .enable (state_q == S_ESPERA),
      .fim    (expirou)
   );
`else
   assign expirou = 1'b0;
   if (TIMEOUT_CYCLES < 2) begin : g_tc_unused
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INICIAL:       if (iniciar) state_d = S_PREPARA;
         S_PREPARA:       state_d = S_INICIO_RODADA;
         S_INICIO_RODADA: state_d = S_ESPERA;
         S_ESPERA: begin
            if (jogada)       state_d = S_REGISTRA;
            else if (expirou) state_d = S_FIM_TIMEOUT;
         end
         S_REGISTRA:      state_d = S_COMPARA;
         S_COMPARA: begin
            if (!igual)            state_d = S_FIM_ERRO;
            else if (fimC && fimL) state_d = S_FIM_ACERTO;
            else if (fimC)         state_d = S_PROX_RODADA;
            else                   state_d = S_PROX_JOGADA;
         end
         S_PROX_JOGADA:   state_d = S_ESPERA;
         S_PROX_RODADA:   state_d = S_INICIO_RODADA;
         S_FIM_ACERTO,
         S_FIM_ERRO:      if (iniciar) state_d = S_PREPARA;
`ifdef UNIDADE_CONTROLE_RODADAS_TIMEOUT_EN
         S_FIM_TIMEOUT:   if (iniciar) state_d = S_PREPARA;
`endif
         default:         state_d = S_INICIAL;
      endcase
      if (reset) state_d = S_INICIAL;
   end

   always_ff @(posedge clock) state_q <= state_d;

   always_comb begin
      zeraC     = 1'b0;
      contaC    = 1'b0;
      zeraR     = 1'b0;
      registraR = 1'b0;
      zeraL     = 1'b0;
      contaL    = 1'b0;
      acertou   = 1'b0;
      errou     = 1'b0;
      timeout   = 1'b0;
      pronto    = 1'b0;
      case (state_q)
         S_PREPARA: begin
            zeraC = 1'b1;
            zeraR = 1'b1;
            zeraL = 1'b1;
         end
         S_INICIO_RODADA: zeraC     = 1'b1;
         S_REGISTRA:      registraR = 1'b1;
         S_PROX_JOGADA:   contaC    = 1'b1;
         S_PROX_RODADA:   contaL    = 1'b1;
         S_FIM_ACERTO: begin
            acertou = 1'b1;
            pronto  = 1'b1;
         end
         S_FIM_ERRO: begin
            errou  = 1'b1;
            pronto = 1'b1;
         end
`ifdef UNIDADE_CONTROLE_RODADAS_TIMEOUT_EN
         S_FIM_TIMEOUT: begin
            timeout = 1'b1;
            pronto  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign db_estado = state_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas: directed table, corner sequences and a
// randomized run against a game-level reference model.
module tb_unidade_controle_rodadas;
   import exp5_pkg::*;

   localparam int TC = 8;
`ifdef UNIDADE_CONTROLE_RODADAS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1, iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fimC = 1'b0, fimL = 1'b0;
   logic zeraC, contaC, zeraR, registraR, zeraL, contaL, acertou, errou, timeout, pronto;
   logic [3:0] db_estado;
   logic [9:0] outs;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   unidade_controle_rodadas #(.TIMEOUT_CYCLES(TC)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
      .igual(igual), .fimC(fimC), .fimL(fimL),
      .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
      .zeraL(zeraL), .contaL(contaL), .acertou(acertou), .errou(errou),
      .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
   );

   assign outs = {zeraC, contaC, zeraR, registraR, zeraL, contaL, acertou, errou, timeout, pronto};

   // {zeraC,contaC,zeraR,registraR,zeraL,contaL,acertou,errou,timeout,pronto}
   function automatic logic [9:0] exp_outs(input logic [3:0] code);
      case (code)
         4'h1:    return 10'b1010100000;
         4'h2:    return 10'b1000000000;
         4'h4:    return 10'b0001000000;
         4'h6:    return 10'b0100000000;
         4'h7:    return 10'b0000010000;
         4'hA:    return 10'b0000001001;
         4'hE:    return 10'b0000000101;
         4'hC:    return TO_EN ? 10'b0000000011 : 10'b0000000000;
         default: return 10'b0000000000;
      endcase
   endfunction

   task automatic check(input string name, input logic [3:0] exp_code);
      logic [9:0] eo;
      eo = exp_outs(exp_code);
      n_checks++;
      if (db_estado !== exp_code || outs !== eo) begin
         n_fail++;
         $display("FAIL %s: estado=%h outs=%b, expected estado=%h outs=%b",
                  name, db_estado, outs, exp_code, eo);
      end
   endtask

   // stim = {reset, iniciar, jogada, igual, fimC, fimL}
   task automatic cyc(input logic [5:0] stim);
      {reset, iniciar, jogada, igual, fimC, fimL} = stim;
      @(posedge clock);
      #1;
   endtask

   task automatic run(input logic [5:0] stim, input logic [3:0] exp_code, input string name);
      cyc(stim);
      check(name, exp_code);
   endtask

   typedef struct {
      logic [5:0] stim;
      logic [3:0] est;
   } vec_t;

   vec_t win_tbl[16];

   // Reference model: game rules by state code, timeout from ESPERA residence time.
   int m_code;
   int m_esp;

   function automatic void model_step(input logic [5:0] s);
      logic r, i, j, g, c, l;
      int nxt;
      {r, i, j, g, c, l} = s;
      nxt = m_code;
      if (r) nxt = 0;
      else if (m_code == 0) nxt = i ? 1 : 0;
      else if (m_code == 1) nxt = 2;
      else if (m_code == 2) nxt = 3;
      else if (m_code == 3) begin
         if (j) nxt = 4;
         else if (TO_EN && (m_esp + 1 == TC)) nxt = 12;
      end
      else if (m_code == 4) nxt = 5;
      else if (m_code == 5) nxt = !g ? 14 : (c && l) ? 10 : c ? 7 : 6;
      else if (m_code == 6) nxt = 3;
      else if (m_code == 7) nxt = 2;
      else if (m_code == 10 || m_code == 14 || m_code == 12) nxt = i ? 1 : m_code;
      else nxt = 0;
      m_esp  = (nxt == 3 && m_code == 3) ? m_esp + 1 : 0;
      m_code = nxt;
   endfunction

   initial begin
      win_tbl[0]  = '{6'b100000, 4'h0};
      win_tbl[1]  = '{6'b010000, 4'h1};
      win_tbl[2]  = '{6'b000000, 4'h2};
      win_tbl[3]  = '{6'b000000, 4'h3};
      win_tbl[4]  = '{6'b001110, 4'h4};
      win_tbl[5]  = '{6'b000110, 4'h5};
      win_tbl[6]  = '{6'b000110, 4'h7};
      win_tbl[7]  = '{6'b000000, 4'h2};
      win_tbl[8]  = '{6'b000000, 4'h3};
      win_tbl[9]  = '{6'b001100, 4'h4};
      win_tbl[10] = '{6'b000100, 4'h5};
      win_tbl[11] = '{6'b000100, 4'h6};
      win_tbl[12] = '{6'b000000, 4'h3};
      win_tbl[13] = '{6'b001111, 4'h4};
      win_tbl[14] = '{6'b000111, 4'h5};
      win_tbl[15] = '{6'b000111, 4'hA};

      for (int k = 0; k < 16; k++) run(win_tbl[k].stim, win_tbl[k].est, $sformatf("win_row%0d", k));
      for (int k = 0; k < 20; k++) run(6'b000000, 4'hA, "win_hold");

      // Error in round 1, play 0
      run(6'b010000, 4'h1, "err_start");
      run(6'b000000, 4'h2, "err_r0_init");
      run(6'b000000, 4'h3, "err_r0_wait");
      run(6'b001110, 4'h4, "err_r0_reg");
      run(6'b000110, 4'h5, "err_r0_cmp");
      run(6'b000110, 4'h7, "err_r0_next");
      run(6'b000000, 4'h2, "err_r1_init");
      run(6'b000000, 4'h3, "err_r1_wait");
      run(6'b001000, 4'h4, "err_r1_reg");
      run(6'b000000, 4'h5, "err_r1_cmp");
      run(6'b000000, 4'hE, "err_final");
      run(6'b000000, 4'hE, "err_hold");
      run(6'b010000, 4'h1, "err_restart");
      run(6'b000000, 4'h2, "to_init");
      run(6'b000000, 4'h3, "to_wait");

      if (TO_EN) begin
         for (int k = 1; k < TC; k++) run(6'b010000, 4'h3, "to_idle");
         run(6'b000000, 4'hC, "to_expire");
         run(6'b000000, 4'hC, "to_hold");
         run(6'b010000, 4'h1, "to_restart");
         run(6'b000000, 4'h2, "late_init");
         run(6'b000000, 4'h3, "late_wait");
         for (int k = 1; k < TC; k++) run(6'b000000, 4'h3, "late_idle");
         run(6'b001100, 4'h4, "late_jogada_wins");
      end else begin
         for (int k = 0; k < 1000; k++) run(6'b010000, 4'h3, "noto_idle");
         run(6'b001100, 4'h4, "noto_jogada");
      end
      run(6'b000100, 4'h5, "mid_cmp");
      run(6'b000100, 4'h6, "mid_prox");
      run(6'b100000, 4'h0, "mid_reset");
      run(6'b010000, 4'h1, "rst_restart");
      run(6'b000000, 4'h2, "rst_init");
      run(6'b000000, 4'h3, "rst_wait");
      if (TO_EN) begin
         for (int k = 1; k < TC; k++) run(6'b000000, 4'h3, "rst_idle");
         run(6'b000000, 4'hC, "rst_timer_fresh");
      end

      // Randomized run against the reference model
      cyc(6'b100000);
      m_code = 0;
      m_esp  = 0;
      for (int k = 0; k < 3000; k++) begin
         logic [5:0] s;
         s[5] = ($urandom_range(99) < 2);
         s[4] = ($urandom_range(99) < 30);
         s[3] = ($urandom_range(99) < 15);
         s[2] = ($urandom_range(99) < 85);
         s[1] = ($urandom_range(99) < 40);
         s[0] = ($urandom_range(99) < 40);
         model_step(s);
         run(s, 4'(m_code), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
